// File: rtl/pkt_tx_pkg.sv
// Shared constants and FSM state encoding for the packet transmit scheduler.
package pkt_tx_pkg;
  localparam logic [8:0] K281    = 9'h13C;
  localparam logic [8:0] K285    = 9'h1BC;
  localparam logic [8:0] K237    = 9'h1F7;
  localparam int         MIN_GAP = 10;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, GAP} state_t;
endpackage

// File: rtl/pkt_tx_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic found;

  // Outer loop is priority distance from ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && ((int'(ptr) + k) % NREQ) == i) begin
          gnt[i] = 1'b1;
          idx    = IW'(i);
          found  = 1'b1;
        end
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/pkt_tx_sched.sv
// Round-robin framer in front of the CRC-inserting 8b/10b encoder.
// Optional length limit enabled by PKT_TX_SCHED_MAXLEN_EN.
module pkt_tx_sched
  import pkt_tx_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 10,
  parameter int MAX_LEN    = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   src_valid,
  input  logic [NREQ*8-1:0] src_data,
  input  logic [NREQ-1:0]   src_last,
  output logic [NREQ-1:0]   src_ready,
  output logic              pushin,
  output logic [8:0]        datain,
  output logic              startin,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              err_underrun,
  output logic [2:0]        err_id
`ifdef PKT_TX_SCHED_MAXLEN_EN
  , output logic            err_maxlen
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (GAP_CYCLES < MIN_GAP) begin : g_gap_chk
    $error("pkt_tx_sched: GAP_CYCLES below encoder minimum");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("pkt_tx_sched: NREQ out of range 2..8");
  end
  if (MAX_LEN < 1) begin : g_len_chk
    $error("pkt_tx_sched: MAX_LEN must be positive");
  end

  state_t            state_q, state_d;
  logic [1:0]        sync_cnt_q, sync_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              pushin_q, pushin_d;
  logic [8:0]        datain_q, datain_d;
  logic              startin_q, startin_d;
  logic              err_underrun_q, err_underrun_d;
  logic [2:0]        err_id_q, err_id_d;

  logic              sel_valid, sel_last;
  logic [7:0]        sel_data;
  logic [NREQ-1:0]   arb_req, arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;

`ifdef PKT_TX_SCHED_MAXLEN_EN
  localparam int LW = $clog2(MAX_LEN + 1);
  logic [LW-1:0]     len_q, len_d;
  logic [NREQ-1:0]   flush_mask_q, flush_mask_d;
  logic              trunc_q, trunc_d;
  logic              err_maxlen_q, err_maxlen_d;
  logic              flush_win;

  // A truncated source is drained only while nobody owns the encoder.
  assign flush_win = (state_q == GAP) || (state_q == IDLE);
  assign arb_req   = src_valid & ~flush_mask_q;
`else
  assign arb_req   = src_valid;
`endif

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (arb_req),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (state_q == DATA) src_ready = grant_q & src_valid;
`ifdef PKT_TX_SCHED_MAXLEN_EN
    if (flush_win) src_ready = flush_mask_q & src_valid;
`endif
  end

  always_comb begin
    state_d        = state_q;
    sync_cnt_d     = sync_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    rr_d           = rr_q;
    gidx_d         = gidx_q;
    grant_d        = grant_q;
    pushin_d       = 1'b0;
    datain_d       = '0;
    startin_d      = 1'b0;
    err_underrun_d = 1'b0;
    err_id_d       = err_id_q;
`ifdef PKT_TX_SCHED_MAXLEN_EN
    len_d          = len_q;
    flush_mask_d   = flush_mask_q;
    trunc_d        = trunc_q;
    err_maxlen_d   = 1'b0;
    if (flush_win && |(flush_mask_q & src_valid & src_last)) flush_mask_d = '0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d    = arb_gnt;
          gidx_d     = arb_idx;
          rr_d       = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          sync_cnt_d = '0;
          state_d    = SYNC;
`ifdef PKT_TX_SCHED_MAXLEN_EN
          len_d      = '0;
`endif
        end
      end
      SYNC: begin
        pushin_d   = 1'b1;
        datain_d   = K281;
        startin_d  = (sync_cnt_q == 2'd0);
        sync_cnt_d = sync_cnt_q + 2'd1;
        if (sync_cnt_q == 2'd3) state_d = DATA;
      end
      DATA: begin
        if (sel_valid) begin
          pushin_d = 1'b1;
          datain_d = {1'b0, sel_data};
          if (sel_last) state_d = EOP;
`ifdef PKT_TX_SCHED_MAXLEN_EN
          else if (len_q == LW'(MAX_LEN - 1)) begin
            state_d      = EOP;
            flush_mask_d = grant_q;
            trunc_d      = 1'b1;
            err_id_d     = 3'(gidx_q);
          end
          len_d = len_q + 1'b1;
`endif
        end else begin
          // Encoder cannot stall mid-frame: close it out immediately.
          pushin_d       = 1'b1;
          datain_d       = K285;
          err_underrun_d = 1'b1;
          err_id_d       = 3'(gidx_q);
          grant_d        = '0;
          gap_cnt_d      = '0;
          state_d        = GAP;
        end
      end
      EOP: begin
        pushin_d  = 1'b1;
        datain_d  = K285;
        grant_d   = '0;
        gap_cnt_d = '0;
        state_d   = GAP;
`ifdef PKT_TX_SCHED_MAXLEN_EN
        err_maxlen_d = trunc_q;
        trunc_d      = 1'b0;
`endif
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sync_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      rr_q           <= '0;
      gidx_q         <= '0;
      grant_q        <= '0;
      pushin_q       <= 1'b0;
      datain_q       <= '0;
      startin_q      <= 1'b0;
      err_underrun_q <= 1'b0;
      err_id_q       <= '0;
`ifdef PKT_TX_SCHED_MAXLEN_EN
      len_q          <= '0;
      flush_mask_q   <= '0;
      trunc_q        <= 1'b0;
      err_maxlen_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sync_cnt_q     <= sync_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      rr_q           <= rr_d;
      gidx_q         <= gidx_d;
      grant_q        <= grant_d;
      pushin_q       <= pushin_d;
      datain_q       <= datain_d;
      startin_q      <= startin_d;
      err_underrun_q <= err_underrun_d;
      err_id_q       <= err_id_d;
`ifdef PKT_TX_SCHED_MAXLEN_EN
      len_q          <= len_d;
      flush_mask_q   <= flush_mask_d;
      trunc_q        <= trunc_d;
      err_maxlen_q   <= err_maxlen_d;
`endif
    end
  end

  assign pushin       = pushin_q;
  assign datain       = datain_q;
  assign startin      = startin_q;
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign err_underrun = err_underrun_q;
  assign err_id       = err_id_q;
`ifdef PKT_TX_SCHED_MAXLEN_EN
  assign err_maxlen   = err_maxlen_q;
`endif
endmodule

// File: tb/tb_pkt_tx_sched.sv
// Directed bench for pkt_tx_sched: per-source byte queues feed the DUT, outputs are logged per cycle.
module tb_pkt_tx_sched;
  localparam int NREQ = 4;
  localparam int GAPC = 10;
`ifdef PKT_TX_SCHED_MAXLEN_EN
  localparam int MAXL = 4;
`else
  localparam int MAXL = 256;
`endif

  logic              clk, reset;
  logic [NREQ-1:0]   src_valid, src_last, src_ready, grant;
  logic [NREQ*8-1:0] src_data;
  logic              pushin, startin, busy, err_underrun;
  logic [8:0]        datain;
  logic [2:0]        err_id;
`ifdef PKT_TX_SCHED_MAXLEN_EN
  logic              err_maxlen;
`endif

  pkt_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(GAPC), .MAX_LEN(MAXL)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .pushin(pushin), .datain(datain),
    .startin(startin), .grant(grant), .busy(busy), .err_underrun(err_underrun),
    .err_id(err_id)
`ifdef PKT_TX_SCHED_MAXLEN_EN
    , .err_maxlen(err_maxlen)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Source model: queue entries are {last, byte}; popped when the DUT took the head.
  logic [8:0]      sq[NREQ][$];
  logic [NREQ-1:0] rdy_s;

  initial begin
    src_valid = '0; src_data = '0; src_last = '0; rdy_s = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rdy_s[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        if (sq[i].size() > 0) begin
          src_valid[i] = 1'b1; src_data[i*8 +: 8] = sq[i][0][7:0]; src_last[i] = sq[i][0][8];
        end else begin
          src_valid[i] = 1'b0; src_data[i*8 +: 8] = 8'h00; src_last[i] = 1'b0;
        end
      end
      #3 rdy_s = src_ready;
    end
  end

  task automatic load(input int s, input logic [7:0] b[$], input logic last);
    for (int k = 0; k < b.size(); k++) sq[s].push_back({last && (k == b.size() - 1), b[k]});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) sq[i].delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  bit         lp[$], ls[$], lu[$], lm[$];
  logic [8:0] ld[$];
  logic [3:0] lg[$];

  task automatic run_log(input int n);
    lp.delete(); ls.delete(); lu.delete(); lm.delete(); ld.delete(); lg.delete();
    repeat (n) begin
      @(negedge clk);
      lp.push_back(pushin); ld.push_back(datain); ls.push_back(startin);
      lg.push_back(grant);  lu.push_back(err_underrun);
`ifdef PKT_TX_SCHED_MAXLEN_EN
      lm.push_back(err_maxlen);
`else
      lm.push_back(1'b0);
`endif
    end
  endtask

  // Beyond the log reads as "pushing garbage" so a short log cannot pass.
  function automatic logic [9:0] pat(input int i);
    return (i < lp.size()) ? {lp[i], ld[i]} : 10'h3FF;
  endfunction

  task automatic chk_frame(input string tag, input int from, input logic [7:0] b[$],
                           input logic [3:0] g, input logic ur, output int eop);
    int st, nz;
    st = -1;
    for (int i = from; i < lp.size(); i++) if (lp[i] && ls[i]) begin st = i; break; end
    chk({tag, " start found"}, 32'(st >= 0), 1);
    eop = from;
    if (st < 0) return;
    chk({tag, " grant"}, lg[st], g);
    for (int k = 0; k < 4; k++) chk($sformatf("%s sync%0d", tag, k), pat(st + k), {1'b1, 9'h13C});
    chk({tag, " startin once"}, 32'(ls[st + 1]), 0);
    for (int k = 0; k < b.size(); k++)
      chk($sformatf("%s data%0d", tag, k), pat(st + 4 + k), {2'b10, b[k]});
    eop = st + 4 + b.size();
    chk({tag, " grant at last data"}, lg[eop - 1], g);
    chk({tag, " eop"}, pat(eop), {1'b1, 9'h1BC});
    chk({tag, " underrun flag"}, 32'(lu[eop]), 32'(ur));
    nz = 0;
    for (int j = 1; j <= GAPC; j++) if (pat(eop + j) == 10'h000) nz++;
    chk({tag, " gap idle"}, nz, GAPC);
  endtask

  initial begin
    int e1, e2, st2, nu, seen;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst pushin", pushin, 0);
    chk("rst datain", datain, 0);
    chk("rst startin", startin, 0);
    chk("rst grant", grant, 0);
    chk("rst busy", busy, 0);
    chk("rst err", {err_underrun, err_id}, 0);
    chk("rst ready", src_ready, 0);
    do_reset();

    // Single 3-byte packet from source 0.
    load(0, '{8'h11, 8'h22, 8'h33}, 1'b1);
    run_log(40);
    chk_frame("t1", 0, '{8'h11, 8'h22, 8'h33}, 4'b0001, 1'b0, e1);

    // Sources 0 and 2 together from rr=0; one arbitration cycle follows the gap.
    do_reset();
    load(0, '{8'hA1, 8'hA2}, 1'b1);
    load(2, '{8'hC1}, 1'b1);
    run_log(60);
    chk_frame("t2a", 0, '{8'hA1, 8'hA2}, 4'b0001, 1'b0, e1);
    chk_frame("t2b", e1 + 1, '{8'hC1}, 4'b0100, 1'b0, e2);
    st2 = e2 - 5;
    chk("t2 gap len", st2 - e1 - 1, GAPC + 1);

    // All four continuously valid: 0,1,2,3,0.
    do_reset();
    load(0, '{8'hB0}, 1'b1); load(0, '{8'hB4}, 1'b1);
    load(1, '{8'hB1}, 1'b1); load(2, '{8'hB2}, 1'b1); load(3, '{8'hB3}, 1'b1);
    run_log(110);
    e1 = 0;
    chk_frame("rr0", e1 + 1, '{8'hB0}, 4'b0001, 1'b0, e1);
    chk_frame("rr1", e1 + 1, '{8'hB1}, 4'b0010, 1'b0, e1);
    chk_frame("rr2", e1 + 1, '{8'hB2}, 4'b0100, 1'b0, e1);
    chk_frame("rr3", e1 + 1, '{8'hB3}, 4'b1000, 1'b0, e1);
    chk_frame("rr4", e1 + 1, '{8'hB4}, 4'b0001, 1'b0, e1);

    // Underrun: source 1 stops after two bytes.
    do_reset();
    load(1, '{8'h55, 8'h66}, 1'b0);
    run_log(40);
    chk_frame("t3", 0, '{8'h55, 8'h66}, 4'b0010, 1'b1, e1);
    nu = 0;
    foreach (lu[i]) if (lu[i]) nu++;
    chk("t3 underrun pulses", nu, 1);
    chk("t3 err_id", err_id, 1);

    // Asynchronous reset in the middle of DATA.
    do_reset();
    load(2, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b1);
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (pushin && !datain[8]) seen = 1;
    end
    chk("t4 data seen", seen, 1);
    #1 reset = 1'b1;
    #1;
    chk("t4 async outs", {pushin, datain, startin, err_underrun}, 0);
    chk("t4 async grant", grant, 0);
    chk("t4 async busy", {busy, src_ready}, 0);
    for (int i = 0; i < NREQ; i++) sq[i].delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    load(3, '{8'h77}, 1'b1);
    run_log(40);
    chk_frame("t4", 0, '{8'h77}, 4'b1000, 1'b0, e1);

`ifdef PKT_TX_SCHED_MAXLEN_EN
    // 6-byte packet truncated at 4; remaining bytes drained, next packet clean.
    do_reset();
    load(0, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b1);
    load(0, '{8'h09}, 1'b1);
    run_log(60);
    chk_frame("t5a", 0, '{8'h01, 8'h02, 8'h03, 8'h04}, 4'b0001, 1'b0, e1);
    chk("t5 maxlen pulse", 32'(lm[e1]), 1);
    chk_frame("t5b", e1 + 1, '{8'h09}, 4'b0001, 1'b0, e2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
